// File: rtl/sc_div_pkg.sv
// Shared types and defaults for the stochastic-computing divider sequencer.
package sc_div_pkg;

    localparam int unsigned SC_DIV_LOGLEN_DEF = 8;
    localparam int unsigned SC_DIV_WARMUP_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WARM,
        ST_RUN,
        ST_DONE
    } sc_div_state_t;

    // Phase counter must hold both WARMUP (up to 255) and any stream length.
    function automatic int unsigned cnt_width(input int unsigned loglen);
        return (loglen > 8) ? loglen : 8;
    endfunction

endpackage

// File: rtl/sc_len_cnt.sv
// Loadable down-counter with zero flag; times the WARM and RUN phases.
module sc_len_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sc_div_seq.sv
// Run sequencer for a stochastic divider: clear, warm-up, count quotient ones, hand off result.
module sc_div_seq
    import sc_div_pkg::*;
#(
    parameter int unsigned LOGLEN = SC_DIV_LOGLEN_DEF,
    parameter int unsigned WARMUP = SC_DIV_WARMUP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LOGLEN-1:0] len,
    input  logic              abort,
    input  logic              q_bit,
    output logic              en,
    output logic              sync_clr,
    output logic              busy,
    output logic [LOGLEN-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int unsigned CW = cnt_width(LOGLEN);

    sc_div_state_t     state_q, state_d;
    logic [LOGLEN-1:0] len_q, len_d;
    logic [LOGLEN-1:0] ones_q, ones_d;
    logic              en_q, sync_clr_q, busy_q, valid_q;

    logic              start_ok;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]     cnt_val;
    logic [CW-1:0]     run_val;

    // Counter is loaded with phase length minus one; the phase ends on the zero flag.
    assign run_val  = CW'(len_q) - CW'(1);
    assign start_ok = start && ((state_q == ST_IDLE) ||
                                ((state_q == ST_DONE) && result_ready));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ones_d   = ones_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (WARMUP != 0) begin
                    state_d  = ST_WARM;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(WARMUP - 1);
                end else if (len_q != '0) begin
                    state_d  = ST_RUN;
                    cnt_load = 1'b1;
                    cnt_val  = run_val;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WARM: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (len_q != '0) begin
                    state_d  = ST_RUN;
                    cnt_load = 1'b1;
                    cnt_val  = run_val;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN: begin
                ones_d = ones_q + LOGLEN'(q_bit);
                if (cnt_zero) state_d = ST_DONE;
                else          cnt_dec = 1'b1;
            end
            ST_DONE: begin
                if (result_ready) state_d = start_ok ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_ok) begin
            len_d  = len;
            ones_d = '0;
        end

        if (abort && ((state_q == ST_CLEAR) || (state_q == ST_WARM) || (state_q == ST_RUN))) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ones_q     <= '0;
            en_q       <= 1'b0;
            sync_clr_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ones_q     <= ones_d;
            en_q       <= (state_d == ST_WARM) || (state_d == ST_RUN);
            sync_clr_q <= (state_d == ST_CLEAR);
            busy_q     <= (state_d != ST_IDLE);
            valid_q    <= (state_d == ST_DONE);
        end
    end

    sc_len_cnt #(
        .W (CW)
    ) u_len_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign en           = en_q;
    assign sync_clr     = sync_clr_q;
    assign busy         = busy_q;
    assign result       = ones_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_sc_div_seq.sv
// Randomized scoreboard bench for sc_div_seq (WARMUP=4 main instance, WARMUP=0 side instance).
module tb_sc_div_seq;

    localparam int unsigned W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, q_bit, result_ready;
    logic [7:0] len;
    logic       en, sync_clr, busy, result_valid;
    logic [7:0] result;

    logic       z_start, z_q_bit, z_ready, z_abort;
    logic [7:0] z_len;
    logic       z_en, z_sync_clr, z_busy, z_valid;
    logic [7:0] z_result;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        int unsigned res;
        int unsigned cyc;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sc_div_seq #(.LOGLEN(8), .WARMUP(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort), .q_bit(q_bit),
        .en(en), .sync_clr(sync_clr), .busy(busy), .result(result),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    sc_div_seq #(.LOGLEN(8), .WARMUP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(z_start), .len(z_len), .abort(z_abort), .q_bit(z_q_bit),
        .en(z_en), .sync_clr(z_sync_clr), .busy(z_busy), .result(z_result),
        .result_valid(z_valid), .result_ready(z_ready)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per result_valid episode and watches result stability.
    bit          in_done = 1'b0;
    logic [7:0]  held;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_done = 1'b0;
        end else if (result_valid) begin
            if (!in_done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("valid_cycle", cyc, e.cyc);
                end
                held    = result;
                in_done = 1'b1;
            end else begin
                check("result_stable", result, held);
            end
            if (result_ready) in_done = 1'b0;
        end
    end

    // One run: expected count is the number of ones in the RUN window of the driven stream.
    task automatic run(input int unsigned l, input int unsigned mode,
                       input int unsigned abort_at, input int unsigned hold);
        bit bits [0:511];
        int unsigned acc, ones, last;
        last = W + 1 + l;
        ones = 0;
        for (int unsigned c = 1; c <= last; c++) begin
            case (mode)
                0:       bits[c] = 1'b1;
                1:       bits[c] = (c < W + 2) || (((c - W - 2) % 2) == 0);
                default: bits[c] = 1'($urandom_range(0, 1));
            endcase
            if (c >= W + 2 && bits[c]) ones++;
        end
        start = 1'b1;
        len   = 8'(l);
        @(posedge clk); #1;
        acc = cyc;
        if (abort_at == 0) sbq.push_back('{ones, acc + last});
        start = 1'b0;
        for (int unsigned c = 1; c <= last; c++) begin
            q_bit = bits[c];
            abort = (c == abort_at);
            len   = 8'($urandom);
            check("sync_clr", sync_clr, c == 1);
            check("en", en, c >= 2);
            check("busy", busy, 1);
            check("valid_early", result_valid, 0);
            @(posedge clk); #1;
            if (c == abort_at) begin
                abort = 1'b0;
                check("abort_en", en, 0);
                check("abort_busy", busy, 0);
                check("abort_sync_clr", sync_clr, 0);
                check("abort_valid", result_valid, 0);
                return;
            end
        end
        q_bit = 1'b0;
        check("done_en", en, 0);
        check("done_sync_clr", sync_clr, 0);
        check("done_busy", busy, 1);
        check("done_valid", result_valid, 1);
        if (hold == 0) begin
            result_ready = 1'b1;
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
        end else begin
            result_ready = 1'b0;
            for (int unsigned h = 0; h < hold; h++) begin
                start = 1'b1;
                len   = 8'($urandom);
                @(posedge clk); #1;
                check("hold_busy", busy, 1);
                check("hold_sync_clr", sync_clr, 0);
                check("hold_valid", result_valid, 1);
                check("hold_en", en, 0);
            end
            start = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; q_bit = 1'b0; len = '0; result_ready = 1'b1;
        z_start = 1'b0; z_abort = 1'b0; z_q_bit = 1'b1; z_len = '0; z_ready = 1'b1;
        #12;
        check("rst_en", en, 0);
        check("rst_sync_clr", sync_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_z_busy", z_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(8, 0, 0, 0);
        run(10, 1, 0, 0);
        run(0, 2, 0, 0);
        run(1, 2, 0, 0);
        for (int i = 0; i < 16; i++) run($urandom_range(0, 40), 2, 0, 0);
        run(255, 2, 0, 0);

        run(8, 2, W + 4, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("post_abort_busy", busy, 0);
        end
        run(9, 2, 0, 0);

        run(6, 2, 0, 5);
        result_ready = 1'b1;
        run(7, 2, 0, 0);

        start = 1'b1; len = 8'd20;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("warm_en", en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_sync_clr", sync_clr, 0);
        check("async_rst_result", result, 0);
        check("async_rst_valid", result_valid, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_idle", busy, 0);
        end
        run(12, 2, 0, 0);

        z_start = 1'b1; z_len = 8'd0;
        @(posedge clk); #1;
        z_start = 1'b0;
        check("z0_sync_clr", z_sync_clr, 1);
        check("z0_en", z_en, 0);
        check("z0_valid_early", z_valid, 0);
        @(posedge clk); #1;
        check("z0_valid", z_valid, 1);
        check("z0_result", z_result, 0);
        check("z0_en_done", z_en, 0);
        @(posedge clk); #1;
        check("z0_idle", z_busy, 0);

        z_start = 1'b1; z_len = 8'd3;
        @(posedge clk); #1;
        z_start = 1'b0;
        for (int unsigned c = 1; c <= 4; c++) begin
            check("z3_sync_clr", z_sync_clr, c == 1);
            check("z3_en", z_en, c >= 2);
            @(posedge clk); #1;
        end
        check("z3_valid", z_valid, 1);
        check("z3_result", z_result, 3);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
